// File: rtl/xalp_axi_to_reg_bridge.sv
// AXI4 responder bridging the xbar peripheral port onto a 32-bit reg bus.
// One beat per reg access, one transaction in flight, INCR/FIXED bursts.
package xalp_axi_pkg;
  localparam int AddrWidth    = 64;
  localparam int AxiDataWidth = 64;
  localparam int RegDataWidth = 32;
  localparam int IdWidth      = 6;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic                      aw_valid;
    logic [IdWidth-1:0]        aw_id;
    logic [AddrWidth-1:0]      aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic                      w_valid;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;
    logic                      ar_valid;
    logic [IdWidth-1:0]        ar_id;
    logic [AddrWidth-1:0]      ar_addr;
    logic [7:0]                ar_len;
    logic [2:0]                ar_size;
    logic [1:0]                ar_burst;
    logic                      b_ready;
    logic                      r_ready;
  } axi_slv_req_t;

  typedef struct packed {
    logic                    aw_ready;
    logic                    w_ready;
    logic                    ar_ready;
    logic                    b_valid;
    logic [IdWidth-1:0]      b_id;
    logic [1:0]              b_resp;
    logic                    r_valid;
    logic [IdWidth-1:0]      r_id;
    logic [AxiDataWidth-1:0] r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
  } axi_slv_rsp_t;

  typedef struct packed {
    logic                      valid;
    logic                      write;
    logic [AddrWidth-1:0]      addr;
    logic [RegDataWidth-1:0]   wdata;
    logic [RegDataWidth/8-1:0] wstrb;
  } reg_req_t;

  typedef struct packed {
    logic                    ready;
    logic                    error;
    logic [RegDataWidth-1:0] rdata;
  } reg_rsp_t;
endpackage

module xalp_axi_to_reg_bridge
  import xalp_axi_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  axi_slv_req_t axi_req_i,
  output axi_slv_rsp_t axi_rsp_o,
  output reg_req_t     reg_req_o,
  input  reg_rsp_t     reg_rsp_i
);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_REG, WR_B, RD_REG, RD_R
  } state_e;

  state_e                  state_q;
  logic                    prio_wr_q;
  logic [IdWidth-1:0]      id_q;
  logic [AddrWidth-1:0]    addr_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q;
  logic                    w_ready_q;
  logic                    b_valid_q;
  logic [1:0]              b_resp_q;
  logic                    r_valid_q;
  logic [AxiDataWidth-1:0] r_data_q;
  logic [1:0]              r_resp_q;
  logic                    r_last_q;
  logic                    reg_valid_q;
  logic                    reg_write_q;
  logic [RegDataWidth-1:0] reg_wdata_q;
  logic [3:0]              reg_wstrb_q;

  logic                 idle;
  logic                 pick_aw;
  logic                 pick_ar;
  logic                 aw_hs;
  logic                 ar_hs;
  logic                 w_hs;
  logic                 reg_hs;
  logic                 b_hs;
  logic                 r_hs;
  logic                 legal;
  logic                 ar_legal;
  logic                 last_beat;
  logic                 beat_err;
  logic [AddrWidth-1:0] addr_nxt;
  logic                 unused_w_last;

  assign unused_w_last = axi_req_i.w_last;

  assign idle    = (state_q == IDLE);
  assign pick_aw = axi_req_i.aw_valid
                 & (~axi_req_i.ar_valid | prio_wr_q);
  assign pick_ar = axi_req_i.ar_valid
                 & (~axi_req_i.aw_valid | ~prio_wr_q);
  assign aw_hs   = idle & pick_aw;
  assign ar_hs   = idle & pick_ar;
  assign w_hs    = w_ready_q & axi_req_i.w_valid;
  assign reg_hs  = reg_valid_q & reg_rsp_i.ready;
  assign b_hs    = b_valid_q & axi_req_i.b_ready;
  assign r_hs    = r_valid_q & axi_req_i.r_ready;

  assign legal    = (size_q <= 3'd2) & (burst_q != BURST_WRAP);
  assign ar_legal = (axi_req_i.ar_size <= 3'd2)
                  & (axi_req_i.ar_burst != BURST_WRAP);
  assign last_beat = (cnt_q == len_q);
  assign beat_err  = err_q | reg_rsp_i.error;
  assign addr_nxt  = (burst_q == BURST_FIXED) ? addr_q
                   : addr_q + (64'd1 << size_q);

  // Drive AXI response channels from registered state
  always_comb begin
    axi_rsp_o          = '0;
    axi_rsp_o.aw_ready = aw_hs;
    axi_rsp_o.ar_ready = ar_hs;
    axi_rsp_o.w_ready  = w_ready_q;
    axi_rsp_o.b_valid  = b_valid_q;
    axi_rsp_o.b_id     = id_q;
    axi_rsp_o.b_resp   = b_resp_q;
    axi_rsp_o.r_valid  = r_valid_q;
    axi_rsp_o.r_id     = id_q;
    axi_rsp_o.r_data   = r_data_q;
    axi_rsp_o.r_resp   = r_resp_q;
    axi_rsp_o.r_last   = r_last_q;
  end

  // Reg bus request is held in flops; addr is the live beat address
  always_comb begin
    reg_req_o       = '0;
    reg_req_o.valid = reg_valid_q;
    reg_req_o.write = reg_write_q;
    reg_req_o.addr  = addr_q;
    reg_req_o.wdata = reg_wdata_q;
    reg_req_o.wstrb = reg_wstrb_q;
  end

  // Transaction FSM: arbitration, beat sequencing and response generation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prio_wr_q   <= 1'b1;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      w_ready_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      b_resp_q    <= RESP_OKAY;
      r_valid_q   <= 1'b0;
      r_data_q    <= '0;
      r_resp_q    <= RESP_OKAY;
      r_last_q    <= 1'b0;
      reg_valid_q <= 1'b0;
      reg_write_q <= 1'b0;
      reg_wdata_q <= '0;
      reg_wstrb_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (aw_hs | ar_hs) begin
            cnt_q <= '0;
            err_q <= 1'b0;
            if (axi_req_i.aw_valid & axi_req_i.ar_valid)
              prio_wr_q <= ~prio_wr_q;
          end
          if (aw_hs) begin
            id_q      <= axi_req_i.aw_id;
            addr_q    <= axi_req_i.aw_addr;
            len_q     <= axi_req_i.aw_len;
            size_q    <= axi_req_i.aw_size;
            burst_q   <= axi_req_i.aw_burst;
            w_ready_q <= 1'b1;
            state_q   <= WR_DATA;
          end else if (ar_hs) begin
            id_q    <= axi_req_i.ar_id;
            addr_q  <= axi_req_i.ar_addr;
            len_q   <= axi_req_i.ar_len;
            size_q  <= axi_req_i.ar_size;
            burst_q <= axi_req_i.ar_burst;
            if (ar_legal) begin
              reg_valid_q <= 1'b1;
              reg_write_q <= 1'b0;
              state_q     <= RD_REG;
            end else begin
              r_valid_q <= 1'b1;
              r_data_q  <= '0;
              r_resp_q  <= RESP_SLVERR;
              r_last_q  <= (axi_req_i.ar_len == 8'd0);
              state_q   <= RD_R;
            end
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            reg_wdata_q <= addr_q[2] ? axi_req_i.w_data[63:32]
                                     : axi_req_i.w_data[31:0];
            reg_wstrb_q <= addr_q[2] ? axi_req_i.w_strb[7:4]
                                     : axi_req_i.w_strb[3:0];
            if (legal) begin
              w_ready_q   <= 1'b0;
              reg_valid_q <= 1'b1;
              reg_write_q <= 1'b1;
              state_q     <= WR_REG;
            end else begin
              err_q <= 1'b1;
              if (last_beat) begin
                w_ready_q <= 1'b0;
                b_valid_q <= 1'b1;
                b_resp_q  <= RESP_SLVERR;
                state_q   <= WR_B;
              end else begin
                cnt_q  <= cnt_q + 8'd1;
                addr_q <= addr_nxt;
              end
            end
          end
        end
        WR_REG: begin
          if (reg_hs) begin
            reg_valid_q <= 1'b0;
            reg_write_q <= 1'b0;
            err_q       <= beat_err;
            if (last_beat) begin
              b_valid_q <= 1'b1;
              b_resp_q  <= beat_err ? RESP_SLVERR : RESP_OKAY;
              state_q   <= WR_B;
            end else begin
              cnt_q     <= cnt_q + 8'd1;
              addr_q    <= addr_nxt;
              w_ready_q <= 1'b1;
              state_q   <= WR_DATA;
            end
          end
        end
        WR_B: begin
          if (b_hs) begin
            b_valid_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        RD_REG: begin
          if (reg_hs) begin
            reg_valid_q <= 1'b0;
            r_valid_q   <= 1'b1;
            r_data_q    <= {reg_rsp_i.rdata, reg_rsp_i.rdata};
            r_resp_q    <= reg_rsp_i.error ? RESP_SLVERR : RESP_OKAY;
            r_last_q    <= last_beat;
            state_q     <= RD_R;
          end
        end
        RD_R: begin
          if (r_hs) begin
            if (last_beat) begin
              r_valid_q <= 1'b0;
              r_last_q  <= 1'b0;
              state_q   <= IDLE;
            end else begin
              cnt_q  <= cnt_q + 8'd1;
              addr_q <= addr_nxt;
              if (legal) begin
                r_valid_q   <= 1'b0;
                r_last_q    <= 1'b0;
                reg_valid_q <= 1'b1;
                reg_write_q <= 1'b0;
                state_q     <= RD_REG;
              end else begin
                r_data_q <= '0;
                r_resp_q <= RESP_SLVERR;
                r_last_q <= (cnt_q + 8'd1 == len_q);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xalp_axi_to_reg_bridge.sv
// Randomised scoreboard bench for the AXI to reg bridge.
// Expected reg accesses and B/R beats are derived from burst arithmetic.
module tb_xalp_axi_to_reg_bridge;
  import xalp_axi_pkg::*;

  localparam logic [63:0] PERIPH = 64'h0000_0000_4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        aw_valid = 0, w_valid = 0, ar_valid = 0;
  logic [5:0]  aw_id = 0, ar_id = 0;
  logic [63:0] aw_addr = 0, ar_addr = 0, w_data = 0;
  logic [7:0]  aw_len = 0, ar_len = 0, w_strb = 0;
  logic [2:0]  aw_size = 0, ar_size = 0;
  logic [1:0]  aw_burst = 0, ar_burst = 0;
  logic        w_last = 0, b_ready = 0, r_ready = 0;
  logic        reg_ready = 0, reg_error = 0;
  logic [31:0] reg_rdata = 0;
  bit          stall = 0;

  axi_slv_req_t req;
  axi_slv_rsp_t rsp;
  reg_req_t     rreq;
  reg_rsp_t     rrsp;

  always_comb begin
    req = '0;
    req.aw_valid = aw_valid; req.aw_id = aw_id; req.aw_addr = aw_addr;
    req.aw_len = aw_len; req.aw_size = aw_size; req.aw_burst = aw_burst;
    req.w_valid = w_valid; req.w_data = w_data; req.w_strb = w_strb;
    req.w_last = w_last;
    req.ar_valid = ar_valid; req.ar_id = ar_id; req.ar_addr = ar_addr;
    req.ar_len = ar_len; req.ar_size = ar_size; req.ar_burst = ar_burst;
    req.b_ready = b_ready; req.r_ready = r_ready;
  end

  always_comb begin
    rrsp = '0;
    rrsp.ready = reg_ready;
    rrsp.error = reg_error;
    rrsp.rdata = reg_rdata;
  end

  xalp_axi_to_reg_bridge dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .axi_req_i(req),
    .axi_rsp_o(rsp),
    .reg_req_o(rreq),
    .reg_rsp_i(rrsp)
  );

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_reg_t;
  typedef struct {
    logic [5:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    bit          chk_data;
  } exp_r_t;
  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } exp_b_t;

  exp_reg_t exp_reg_q[$];
  exp_r_t   exp_r_q[$];
  exp_b_t   exp_b_q[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] wd_buf [0:255];
  logic [7:0]  ws_buf [0:255];

  function automatic logic [31:0] reg_rd(input logic [63:0] a);
    if (a[15:0] == 16'h1004) return 32'hDEAD_BEEF;
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
  endfunction

  function automatic logic reg_err(input logic [63:0] a);
    return a[6:2] == 5'd5;
  endfunction

  function automatic logic [63:0] beat_addr(input logic [63:0] a,
      input int i, input logic [2:0] size, input logic [1:0] burst);
    if (burst == BURST_FIXED) return a;
    return a + 64'(i) * (64'd1 << size);
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_write(input logic [5:0] id, input logic [63:0] a,
      input int len, input logic [2:0] size, input logic [1:0] burst);
    bit err;
    logic [63:0] ba;
    exp_reg_t e;
    exp_b_t b;
    err = 0;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, i, size, burst);
      if (size > 3'd2 || burst == BURST_WRAP) err = 1;
      else begin
        e.write = 1'b1;
        e.addr  = ba;
        e.wdata = ba[2] ? wd_buf[i][63:32] : wd_buf[i][31:0];
        e.wstrb = ba[2] ? ws_buf[i][7:4] : ws_buf[i][3:0];
        exp_reg_q.push_back(e);
        if (reg_err(ba)) err = 1;
      end
    end
    b.id = id;
    b.resp = err ? RESP_SLVERR : RESP_OKAY;
    exp_b_q.push_back(b);
  endtask

  task automatic expect_read(input logic [5:0] id, input logic [63:0] a,
      input int len, input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] ba;
    exp_reg_t e;
    exp_r_t r;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, i, size, burst);
      r.id = id;
      r.last = (i == len);
      if (size > 3'd2 || burst == BURST_WRAP) begin
        r.data = '0; r.resp = RESP_SLVERR; r.chk_data = 0;
      end else begin
        e.write = 1'b0; e.addr = ba; e.wdata = '0; e.wstrb = '0;
        exp_reg_q.push_back(e);
        r.data = {reg_rd(ba), reg_rd(ba)};
        r.resp = reg_err(ba) ? RESP_SLVERR : RESP_OKAY;
        r.chk_data = 1;
      end
      exp_r_q.push_back(r);
    end
  endtask

  task automatic wait_hs(input int which, output bit ok);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ((which == 0 && rsp.aw_ready) || (which == 1 && rsp.w_ready) ||
          (which == 2 && rsp.ar_ready)) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL handshake_timeout ch=%0d: got no ready, required ready",
               which);
    end
  endtask

  task automatic do_write(input logic [5:0] id, input logic [63:0] a,
      input int len, input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    aw_id = id; aw_addr = a; aw_len = 8'(len);
    aw_size = size; aw_burst = burst; aw_valid = 1;
    wait_hs(0, ok);
    if (ok) expect_write(id, a, len, size, burst);
    @(posedge clk); #1;
    aw_valid = 0;
    if (!ok) return;
    for (int i = 0; i <= len; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      w_data = wd_buf[i]; w_strb = ws_buf[i];
      w_last = (i == len); w_valid = 1;
      wait_hs(1, ok);
      @(posedge clk); #1;
      w_valid = 0;
      if (!ok) return;
    end
  endtask

  task automatic do_read(input logic [5:0] id, input logic [63:0] a,
      input int len, input logic [2:0] size, input logic [1:0] burst);
    bit ok;
    ar_id = id; ar_addr = a; ar_len = 8'(len);
    ar_size = size; ar_burst = burst; ar_valid = 1;
    wait_hs(2, ok);
    if (ok) expect_read(id, a, len, size, burst);
    @(posedge clk); #1;
    ar_valid = 0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (exp_reg_q.size() == 0 && exp_r_q.size() == 0 &&
          exp_b_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout: pending reg=%0d r=%0d b=%0d, required 0",
               exp_reg_q.size(), exp_r_q.size(), exp_b_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1;
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    exp_reg_q.delete(); exp_r_q.delete(); exp_b_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 0;
  endtask

  // Reg slave: random ready, data and error derived from the address
  always @(posedge clk) begin
    #1;
    reg_ready = !rst && rreq.valid && !stall && ($urandom_range(0, 2) == 0);
    reg_rdata = reg_rd(rreq.addr);
    reg_error = reg_err(rreq.addr);
  end

  // Random backpressure on B and R
  always @(posedge clk) begin
    #1;
    b_ready = ($urandom_range(0, 3) != 0);
    r_ready = ($urandom_range(0, 3) != 0);
  end

  bit          pend_valid = 0;
  logic [63:0] pend_addr = 0;
  exp_reg_t    me;
  exp_r_t      mr;
  exp_b_t      mb;

  // Monitor: pops expectations whenever the DUT completes a handshake
  always @(negedge clk) begin
    if (rst) pend_valid = 0;
    else begin
      if (pend_valid) begin
        chk("reg_hold_valid", rreq.valid, 1'b1);
        chk("reg_hold_addr", rreq.addr, pend_addr);
      end
      if (rreq.valid && reg_ready) begin
        if (exp_reg_q.size() == 0) chk("reg_unexpected", 1'b1, 1'b0);
        else begin
          me = exp_reg_q.pop_front();
          chk("reg_write", rreq.write, me.write);
          chk("reg_addr", rreq.addr, me.addr);
          if (me.write) begin
            chk("reg_wdata", rreq.wdata, me.wdata);
            chk("reg_wstrb", rreq.wstrb, me.wstrb);
          end
        end
      end
      pend_valid = rreq.valid && !reg_ready;
      pend_addr  = rreq.addr;
      if (rsp.r_valid && r_ready) begin
        if (exp_r_q.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
        else begin
          mr = exp_r_q.pop_front();
          chk("r_id", rsp.r_id, mr.id);
          chk("r_resp", rsp.r_resp, mr.resp);
          chk("r_last", rsp.r_last, mr.last);
          if (mr.chk_data) chk("r_data", rsp.r_data, mr.data);
        end
      end
      if (rsp.b_valid && b_ready) begin
        if (exp_b_q.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else begin
          mb = exp_b_q.pop_front();
          chk("b_id", rsp.b_id, mb.id);
          chk("b_resp", rsp.b_resp, mb.resp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1, "watchdog");
  end

  bit prio_wr;

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_aw_ready", rsp.aw_ready, 1'b0);
    chk("rst_w_ready", rsp.w_ready, 1'b0);
    chk("rst_b_valid", rsp.b_valid, 1'b0);
    chk("rst_r_valid", rsp.r_valid, 1'b0);
    chk("rst_r_data", rsp.r_data, 64'h0);
    chk("rst_reg_valid", rreq.valid, 1'b0);
    @(posedge clk); #1;

    // W presented before any AW must be held off
    w_valid = 1; w_data = 64'hABCD; w_strb = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      chk("w_before_aw", rsp.w_ready, 1'b0);
      @(posedge clk); #1;
    end
    w_valid = 0;

    do_read(6'h2A, PERIPH + 64'h1004, 0, 3'd2, BURST_INCR);
    wait_idle();
    wd_buf[0] = 64'h1122_3344_5566_7788; ws_buf[0] = 8'hF0;
    do_write(6'h15, PERIPH + 64'h1004, 0, 3'd2, BURST_INCR);
    wait_idle();
    do_read(6'h07, 64'h2000, 3, 3'd2, BURST_INCR);
    wait_idle();
    wd_buf[0] = 64'h0123_4567_89AB_CDEF; ws_buf[0] = 8'h0F;
    wd_buf[1] = 64'hFEDC_BA98_7654_3210; ws_buf[1] = 8'hF0;
    do_write(6'h09, PERIPH + 64'h14, 1, 3'd2, BURST_INCR);
    wait_idle();
    do_read(6'h11, PERIPH + 64'h40, 0, 3'd3, BURST_INCR);
    wait_idle();
    do_write(6'h12, PERIPH + 64'h48, 1, 3'd2, BURST_WRAP);
    wait_idle();
    do_read(6'h13, PERIPH + 64'h80, 2, 3'd2, BURST_FIXED);
    wait_idle();

    // Simultaneous AW/AR: write wins from reset, then priority flips
    do_reset();
    prio_wr = 1;
    repeat (2) begin
      wd_buf[0] = {$urandom, $urandom}; ws_buf[0] = 8'($urandom);
      fork
        do_write(6'h21, PERIPH + 64'h200, 0, 3'd2, BURST_INCR);
        do_read(6'h22, PERIPH + 64'h300, 0, 3'd2, BURST_INCR);
        begin
          @(negedge clk);
          chk("arb_aw_ready", rsp.aw_ready, prio_wr);
          chk("arb_ar_ready", rsp.ar_ready, !prio_wr);
        end
      join
      prio_wr = !prio_wr;
      wait_idle();
    end

    // Reset while a read is waiting on the reg bus abandons it
    stall = 1;
    do_read(6'h33, PERIPH + 64'h100, 0, 3'd2, BURST_INCR);
    @(negedge clk);
    chk("rd_reg_valid", rreq.valid, 1'b1);
    @(posedge clk); #1;
    rst = 1;
    exp_reg_q.delete(); exp_r_q.delete(); exp_b_q.delete();
    @(posedge clk); @(negedge clk);
    chk("rst_drop_valid", rreq.valid, 1'b0);
    chk("rst_no_r", rsp.r_valid, 1'b0);
    @(posedge clk); #1;
    rst = 0; stall = 0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("no_r_after_rst", rsp.r_valid, 1'b0);
    chk("no_b_after_rst", rsp.b_valid, 1'b0);
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      logic [63:0] a;
      logic [2:0]  sz;
      logic [1:0]  bu;
      int          ln;
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) a = 64'hFFFF_FFFF_FFFF_FFF0;
      sz = ($urandom_range(0, 5) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       bu = BURST_FIXED;
        1:       bu = BURST_WRAP;
        default: bu = BURST_INCR;
      endcase
      ln = $urandom_range(0, 7);
      for (int i = 0; i <= ln; i++) begin
        wd_buf[i] = {$urandom, $urandom};
        ws_buf[i] = 8'($urandom);
      end
      if ($urandom_range(0, 1) == 0)
        do_write(6'($urandom), a, ln, sz, bu);
      else
        do_read(6'($urandom), a, ln, sz, bu);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
